// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared read/write op encoding for the threshold FIFO
package fifo_pkg;

    typedef enum logic [1:0] {
        OP_NOP       = 2'b00,
        OP_READ      = 2'b01,
        OP_WRITE     = 2'b10,
        OP_READWRITE = 2'b11
    } fifo_op_e;

    // Packs the accepted write/read strobes into one op code
    function automatic fifo_op_e fifo_op(input logic wr, input logic rd);
        return fifo_op_e'({wr, rd});
    endfunction

endpackage

// File: rtl/fifo_thresh_if.sv
// rtl/fifo_thresh_if.sv - request/data/status bundle of the threshold FIFO
interface fifo_thresh_if #(
    parameter int NB_DATA = 8,
    parameter int PTR_LEN = 4
);
    logic               i_write_fifo;
    logic               i_read_fifo;
    logic [NB_DATA-1:0] i_data_to_write;
    logic               i_flush;
    logic               i_clear_flags;
    logic [NB_DATA-1:0] o_data_to_read;
    logic               o_fifo_is_empty;
    logic               o_fifo_is_full;
    logic               o_almost_empty;
    logic               o_almost_full;
    logic [PTR_LEN:0]   o_level;
    logic               o_overflow;
    logic               o_underflow;

    modport master (
        output i_write_fifo, i_read_fifo, i_data_to_write, i_flush, i_clear_flags,
        input  o_data_to_read, o_fifo_is_empty, o_fifo_is_full, o_almost_empty,
               o_almost_full, o_level, o_overflow, o_underflow
    );

    modport slave (
        input  i_write_fifo, i_read_fifo, i_data_to_write, i_flush, i_clear_flags,
        output o_data_to_read, o_fifo_is_empty, o_fifo_is_full, o_almost_empty,
               o_almost_full, o_level, o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_regfile.sv
// rtl/fifo_regfile.sv - FIFO storage, synchronous write and asynchronous read
module fifo_regfile #(
    parameter int NB_DATA = 8,
    parameter int PTR_LEN = 4
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [PTR_LEN-1:0] i_waddr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic [PTR_LEN-1:0] i_raddr,
    output logic [NB_DATA-1:0] o_rdata
);
    localparam int DEPTH = 2 ** PTR_LEN;

    logic [NB_DATA-1:0] r_mem [DEPTH];

    // Storage is deliberately not reset; only the pointers define validity
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fifo_thresh.sv
// rtl/fifo_thresh.sv - FWFT FIFO with level, threshold flags and sticky errors
module fifo_thresh
    import fifo_pkg::*;
#(
    parameter int NB_DATA         = 8,
    parameter int PTR_LEN         = 4,
    parameter int ALMOST_FULL_TH  = 2 ** PTR_LEN - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    fifo_thresh_if.slave  bus
);
    localparam int DEPTH = 2 ** PTR_LEN;
    localparam logic [PTR_LEN:0] LVL_DEPTH = (PTR_LEN + 1)'(DEPTH);
    localparam logic [PTR_LEN:0] LVL_AF    = (PTR_LEN + 1)'(ALMOST_FULL_TH);
    localparam logic [PTR_LEN:0] LVL_AE    = (PTR_LEN + 1)'(ALMOST_EMPTY_TH);

    if (!(ALMOST_EMPTY_TH >= 0 && ALMOST_EMPTY_TH < ALMOST_FULL_TH && ALMOST_FULL_TH <= DEPTH))
    begin : g_bad_thresholds
        $error("fifo_thresh: need 0 <= ALMOST_EMPTY_TH < ALMOST_FULL_TH <= DEPTH");
    end

    logic [PTR_LEN-1:0] r_wr_ptr;
    logic [PTR_LEN-1:0] r_rd_ptr;
    logic [PTR_LEN:0]   r_level;
    logic [PTR_LEN:0]   w_level_nxt;
    logic               r_empty;
    logic               r_full;
    logic               r_almost_empty;
    logic               r_almost_full;
    logic               r_overflow;
    logic               r_underflow;
    logic               w_rd_acc;
    logic               w_wr_acc;
    logic               w_mem_we;
    logic               w_ovf_evt;
    logic               w_unf_evt;
    fifo_op_e           w_op;

    // A read at full frees a slot in the same cycle, so the write may ride along
    assign w_rd_acc = bus.i_read_fifo & ~r_empty;
    assign w_wr_acc = bus.i_write_fifo & (~r_full | w_rd_acc);
    assign w_op     = fifo_op(w_wr_acc, w_rd_acc);
    assign w_mem_we = w_wr_acc & ~bus.i_flush;

    // Errors are not recorded on a flush cycle; read+write on empty is a clean write
    assign w_ovf_evt = bus.i_write_fifo & ~w_wr_acc & ~bus.i_flush;
    assign w_unf_evt = bus.i_read_fifo & r_empty & ~bus.i_write_fifo & ~bus.i_flush;

    fifo_regfile #(
        .NB_DATA (NB_DATA),
        .PTR_LEN (PTR_LEN)
    ) u_regfile (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.i_data_to_write),
        .i_raddr (r_rd_ptr),
        .o_rdata (bus.o_data_to_read)
    );

    // Next occupancy: +1 / -1 / hold, flush forces empty
    always_comb begin
        w_level_nxt = r_level;
        unique case (w_op)
            OP_WRITE: w_level_nxt = r_level + 1'b1;
            OP_READ:  w_level_nxt = r_level - 1'b1;
            default:  w_level_nxt = r_level;
        endcase
        if (bus.i_flush) begin
            w_level_nxt = '0;
        end
    end

    // Pointers, level and level-derived flags, all from the same next level
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
        end else begin
            if (bus.i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level        <= w_level_nxt;
            r_empty        <= (w_level_nxt == '0);
            r_full         <= (w_level_nxt == LVL_DEPTH);
            r_almost_empty <= (w_level_nxt <= LVL_AE);
            r_almost_full  <= (w_level_nxt >= LVL_AF);
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_evt)               r_overflow <= 1'b1;
            else if (bus.i_clear_flags)  r_overflow <= 1'b0;
            if (w_unf_evt)               r_underflow <= 1'b1;
            else if (bus.i_clear_flags)  r_underflow <= 1'b0;
        end
    end

    assign bus.o_level         = r_level;
    assign bus.o_fifo_is_empty = r_empty;
    assign bus.o_fifo_is_full  = r_full;
    assign bus.o_almost_empty  = r_almost_empty;
    assign bus.o_almost_full   = r_almost_full;
    assign bus.o_overflow      = r_overflow;
    assign bus.o_underflow     = r_underflow;
endmodule
